// File: rtl/mem_access_initiator.sv
// Queues read/write commands in a small FIFO and replays them as single-cycle memory strobes.
// Each read waits out the memory latency and is returned on a valid/ready response port.
module mem_access_initiator #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  output logic              write_enable,
  output logic              read_enable,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              cmd_ready_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              we_q, we_d;
  logic              re_q, re_d;

  logic              fifo_write_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] cur_addr_q;
  logic [DATA_W-1:0] cur_wdata_q;

  logic push, pop, wait_done;

  // Pop only looks at the registered occupancy, so a push into an empty FIFO waits an edge.
  assign push      = cmd_valid && cmd_ready_q;
  assign pop       = (state_q == StIdle) && (count_q != '0);
  assign wait_done = (wait_cnt_q == 3'(RD_LATENCY));

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= cmd_write;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
    end
    if (pop) begin
      cur_addr_q  <= fifo_addr_q[rd_ptr_q];
      cur_wdata_q <= fifo_wdata_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      addr_q      <= '0;
      data_in_q   <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CntW'(FIFO_DEPTH));
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      we_q        <= we_d;
      re_q        <= re_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    unique case (state_q)
      StIdle: if (pop) state_d = fifo_write_q[rd_ptr_q] ? StWr : StRd;
      StWr:   state_d = StIdle;
      StRd:   state_d = StWait;
      StWait: begin
        wait_cnt_d = wait_cnt_q + 3'd1;
        if (wait_done) state_d = StResp;
      end
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes trail the state by one edge; the extra WAIT cycle absorbs that lag.
  always_comb begin
    we_d        = 1'b0;
    re_d        = 1'b0;
    addr_d      = addr_q;
    data_in_d   = data_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      StWr: begin
        we_d      = 1'b1;
        addr_d    = cur_addr_q;
        data_in_d = cur_wdata_q;
      end
      StRd: begin
        re_d   = 1'b1;
        addr_d = cur_addr_q;
      end
      StWait: begin
        if (wait_done) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = data_out;
        end
      end
      StResp: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign addr         = addr_q;
  assign data_in      = data_in_q;
  assign write_enable = we_q;
  assign read_enable  = re_q;
  assign busy         = (count_q != '0) || (state_q != StIdle) || we_q || re_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench: instance 0 runs with read latency 1, instance 1 with latency 3.
// Each instance has its own memory model plus strobe and response logs.
module tb_mem_access_initiator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;

  logic [1:0]  cmd_valid_w, cmd_ready_w, rsp_valid_w, we_w, re_w, busy_w;
  logic [31:0] addr_w     [2];
  logic [63:0] din_w      [2];
  logic [63:0] dout_w     [2];
  logic [63:0] rsp_data_w [2];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign cmd_valid_w[0] = cmd_valid & ~sel;
  assign cmd_valid_w[1] = cmd_valid & sel;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : 3;

    logic [63:0] mem  [256];
    logic [63:0] pipe [8];
    int          n_str = 0;
    int          n_rsp = 0;
    int          n_ovl = 0;
    logic        str_wr   [64];
    logic [31:0] str_addr [64];
    logic [63:0] str_data [64];
    logic [63:0] rsp_log  [64];

    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    initial for (int i = 0; i < 8; i++) pipe[i] = '0;

    mem_access_initiator #(
      .ADDR_W(32), .DATA_W(64), .FIFO_DEPTH(4), .RD_LATENCY(Lat)
    ) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .cmd_valid    (cmd_valid_w[g]),
      .cmd_ready    (cmd_ready_w[g]),
      .cmd_write    (cmd_write),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid_w[g]),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data_w[g]),
      .addr         (addr_w[g]),
      .data_in      (din_w[g]),
      .write_enable (we_w[g]),
      .read_enable  (re_w[g]),
      .data_out     (dout_w[g]),
      .busy         (busy_w[g])
    );

    // Memory: write on strobe edge, read data valid Lat cycles after the sample edge.
    always @(posedge clk) begin
      if (we_w[g]) mem[addr_w[g][7:0]] <= din_w[g];
      pipe[0] <= mem[addr_w[g][7:0]];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign dout_w[g] = pipe[Lat-1];

    always @(posedge clk) begin
      if (we_w[g] || re_w[g]) begin
        if (n_str < 64) begin
          str_wr[n_str]   <= we_w[g];
          str_addr[n_str] <= addr_w[g];
          str_data[n_str] <= din_w[g];
        end
        n_str <= n_str + 1;
      end
      if (we_w[g] && re_w[g]) n_ovl <= n_ovl + 1;
      if (rsp_valid_w[g] && rsp_ready) begin
        if (n_rsp < 64) rsp_log[n_rsp] <= rsp_data_w[g];
        n_rsp <= n_rsp + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [63:0] d);
    int n;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready_w[sel] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("push_timeout", 64'd1, 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_w[sel] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid_w[sel] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("rsp_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b, r;
    logic        e_wr   [5];
    logic [31:0] e_addr [5];
    logic [63:0] e_data [5];
    logic [63:0] e_rsp  [4];
    logic [63:0] v;

    sel = 1'b0; rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", 64'(cmd_ready_w[0]), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid_w[0]), 64'd0);
    check_eq("rst_strobes", 64'({we_w[0], re_w[0]}), 64'd0);
    check_eq("rst_addr", 64'(addr_w[0]), 64'd0);
    check_eq("rst_busy", 64'(busy_w), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("cmd_ready_after_rst", 64'(cmd_ready_w), 64'd3);

    // Write then read back at address 100.
    b = g_dut[0].n_str; r = g_dut[0].n_rsp;
    push(1'b1, 32'd100, 64'd100);
    push(1'b0, 32'd100, 64'd0);
    wait_idle();
    check_eq("wr_rd_nstr", 64'(g_dut[0].n_str - b), 64'd2);
    check_eq("wr_is_write", 64'(g_dut[0].str_wr[b]), 64'd1);
    check_eq("wr_addr", 64'(g_dut[0].str_addr[b]), 64'd100);
    check_eq("wr_data", g_dut[0].str_data[b], 64'd100);
    check_eq("rd_is_read", 64'(g_dut[0].str_wr[b+1]), 64'd0);
    check_eq("rd_addr", 64'(g_dut[0].str_addr[b+1]), 64'd100);
    check_eq("wr_rd_nrsp", 64'(g_dut[0].n_rsp - r), 64'd1);
    check_eq("wr_rd_data", g_dut[0].rsp_log[r], 64'd100);
    check_eq("addr_hold", 64'(addr_w[0]), 64'd100);

    // Read of an unwritten location.
    r = g_dut[0].n_rsp;
    push(1'b0, 32'd110, 64'd0);
    wait_idle();
    check_eq("unwritten_nrsp", 64'(g_dut[0].n_rsp - r), 64'd1);
    check_eq("unwritten_data", g_dut[0].rsp_log[r], 64'd0);

    // Response back-pressure for 10 cycles with a write queued behind it.
    rsp_ready = 1'b0;
    r = g_dut[0].n_rsp;
    push(1'b0, 32'd100, 64'd0);
    wait_rsp();
    push(1'b1, 32'd120, 64'd55);
    b = g_dut[0].n_str;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 64'(rsp_valid_w[0]), 64'd1);
      check_eq("stall_data", rsp_data_w[0], 64'd100);
    end
    check_eq("stall_no_strobe", 64'(g_dut[0].n_str - b), 64'd0);
    rsp_ready = 1'b1;
    wait_idle();
    check_eq("stall_nrsp", 64'(g_dut[0].n_rsp - r), 64'd1);
    check_eq("stall_then_wr", 64'(g_dut[0].str_wr[b]), 64'd1);
    check_eq("stall_wr_addr", 64'(g_dut[0].str_addr[b]), 64'd120);

    // Fill the FIFO while a response is held, then drain.
    rsp_ready = 1'b0;
    push(1'b0, 32'd100, 64'd0);
    wait_rsp();
    b = g_dut[0].n_str; r = g_dut[0].n_rsp;
    e_wr[0] = 1'b0; e_addr[0] = 32'd100; e_data[0] = 64'd0;
    e_wr[1] = 1'b1; e_addr[1] = 32'd201; e_data[1] = 64'd7;
    e_wr[2] = 1'b0; e_addr[2] = 32'd120; e_data[2] = 64'd0;
    e_wr[3] = 1'b1; e_addr[3] = 32'd203; e_data[3] = 64'd9;
    e_wr[4] = 1'b0; e_addr[4] = 32'd201; e_data[4] = 64'd0;
    e_rsp[0] = 64'd100; e_rsp[1] = 64'd100; e_rsp[2] = 64'd55; e_rsp[3] = 64'd7;
    for (int i = 0; i < 4; i++) push(e_wr[i], e_addr[i], e_data[i]);
    check_eq("full_cmd_ready", 64'(cmd_ready_w[0]), 64'd0);
    rsp_ready = 1'b1;
    push(e_wr[4], e_addr[4], e_data[4]);
    wait_idle();
    check_eq("fill_nstr", 64'(g_dut[0].n_str - b), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check_eq("fill_kind", 64'(g_dut[0].str_wr[b+i]), 64'(e_wr[i]));
      check_eq("fill_addr", 64'(g_dut[0].str_addr[b+i]), 64'(e_addr[i]));
      if (e_wr[i]) check_eq("fill_wdata", g_dut[0].str_data[b+i], e_data[i]);
    end
    check_eq("fill_nrsp", 64'(g_dut[0].n_rsp - r), 64'd4);
    for (int i = 0; i < 4; i++) check_eq("fill_rsp", g_dut[0].rsp_log[r+i], e_rsp[i]);

    // Reset while waiting on read data with two writes queued.
    push(1'b0, 32'd100, 64'd0);
    push(1'b1, 32'd130, 64'd1);
    push(1'b1, 32'd131, 64'd2);
    rstn = 1'b0;
    @(negedge clk);
    b = g_dut[0].n_str; r = g_dut[0].n_rsp;
    check_eq("midrst_cmd_ready", 64'(cmd_ready_w[0]), 64'd0);
    check_eq("midrst_rsp_valid", 64'(rsp_valid_w[0]), 64'd0);
    check_eq("midrst_rsp_data", rsp_data_w[0], 64'd0);
    check_eq("midrst_strobes", 64'({we_w[0], re_w[0]}), 64'd0);
    check_eq("midrst_addr", 64'(addr_w[0]), 64'd0);
    check_eq("midrst_data_in", din_w[0], 64'd0);
    check_eq("midrst_busy", 64'(busy_w[0]), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready_after", 64'(cmd_ready_w[0]), 64'd1);
    repeat (10) @(negedge clk);
    check_eq("midrst_no_strobe", 64'(g_dut[0].n_str - b), 64'd0);
    check_eq("midrst_no_rsp", 64'(g_dut[0].n_rsp - r), 64'd0);
    check_eq("midrst_idle", 64'(busy_w[0]), 64'd0);

    // Latency-3 instance: alternating write/read over addresses 0..7.
    sel = 1'b1;
    r = g_dut[1].n_rsp; b = g_dut[1].n_str;
    for (int i = 0; i < 8; i++) begin
      v = 64'hA5A5_0000_0000_0000 | (64'(i) * 64'h0101 + 64'd3);
      push(1'b1, 32'(i), v);
      push(1'b0, 32'(i), 64'd0);
    end
    wait_idle();
    check_eq("lat3_nstr", 64'(g_dut[1].n_str - b), 64'd16);
    check_eq("lat3_nrsp", 64'(g_dut[1].n_rsp - r), 64'd8);
    for (int i = 0; i < 8; i++) begin
      v = 64'hA5A5_0000_0000_0000 | (64'(i) * 64'h0101 + 64'd3);
      check_eq("lat3_rsp", g_dut[1].rsp_log[r+i], v);
    end
    check_eq("overlap0", 64'(g_dut[0].n_ovl), 64'd0);
    check_eq("overlap1", 64'(g_dut[1].n_ovl), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_initiator.md
MEM_ACCESS_INITIATOR -- requirements
Module: mem_access_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, 32, memory address width.
REQ-002 SHALL have parameter DATA_W, 64, memory data width.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, command FIFO entries; power of two, 2 to 16.
REQ-004 SHALL have parameter RD_LATENCY, 1, cycles from the read_enable sample edge to valid data_out; 1 to 7.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rstn  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-009 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port cmd_addr  input  ADDR_W  command address.
REQ-011 SHALL have port cmd_wdata  input  DATA_W  write data; ignored for reads.
REQ-012 SHALL have port rsp_valid  output  1  read response available.
REQ-013 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-014 SHALL have port rsp_data  output  DATA_W  read data.
REQ-015 SHALL have port addr  output  ADDR_W  memory address.
REQ-016 SHALL have port data_in  output  DATA_W  memory write data.
REQ-017 SHALL have port write_enable  output  1  memory write strobe.
REQ-018 SHALL have port read_enable  output  1  memory read strobe.
REQ-019 SHALL have port data_out  input  DATA_W  memory read data.
REQ-020 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-021 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready = !fifo_full, registered, independent of same-cycle pop.
REQ-022 SHALL store commands in FIFO order; pointers wrap modulo FIFO_DEPTH; full/empty from an occupancy counter 0..FIFO_DEPTH.
REQ-023 SHALL implement FSM states IDLE, WR, RD, WAIT, RESP; every memory-side output is registered.
REQ-024 SHALL, in IDLE with the FIFO non-empty, pop the head and go to WR if cmd_write=1, else RD; with the FIFO empty, stay in IDLE.
REQ-025 SHALL drive write_enable=1 with addr/data_in = command fields for exactly one cycle in WR, then return to IDLE; a write produces no response.
REQ-026 SHALL drive read_enable=1 with addr = command address for exactly one cycle in RD, then enter WAIT.
REQ-027 SHALL count RD_LATENCY cycles in WAIT, capture data_out into rsp_data on the final count, set rsp_valid=1, and enter RESP.
REQ-028 SHALL, in RESP, hold rsp_valid and rsp_data stable until rsp_ready=1, then clear rsp_valid and return to IDLE; no memory access starts while in RESP.
REQ-029 SHALL give a command accepted at edge k its strobe in the cycle after edge k+2, provided the FSM is in IDLE at edge k+1; push into an empty FIFO is never popped on the same edge.
REQ-030 SHALL never assert write_enable and read_enable together; both SHALL be 0 in IDLE, WAIT and RESP.
REQ-031 SHALL hold addr/data_in at their last driven values when no strobe is asserted.
REQ-032 SHALL allow push and pop on the same edge when the FIFO is neither empty nor full, leaving occupancy unchanged.

Reset
REQ-033 SHALL, on an edge with rstn=0, set FSM to IDLE, empty the FIFO, and drive cmd_ready=0, rsp_valid=0, rsp_data=0, addr=0, data_in=0, write_enable=0, read_enable=0, busy=0.
REQ-034 SHALL drive cmd_ready=1 on the first edge with rstn=1.
REQ-035 SHALL, on reset mid-operation (any state, including WAIT or RESP), discard queued commands and any pending read data; no response is issued for them.

Verification
REQ-036 Write addr=100, wdata=100, then read addr=100 with a memory model of RD_LATENCY=1 -> one write_enable pulse at addr 100, then one read_enable pulse; rsp_valid with rsp_data=100.
REQ-037 Read addr=110 (never written, model resets to 0) -> rsp_data=0; exactly one rsp_valid handshake.
REQ-038 Push 5 commands back-to-back with FIFO_DEPTH=4 while rsp_ready=0 -> cmd_ready falls after 4 accepts; all 5 strobes issue in order once responses drain.
REQ-039 Read with rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable for 10 cycles, no strobes issued, one handshake when rsp_ready=1.
REQ-040 Assert rstn=0 for one cycle in WAIT with 2 commands queued -> all outputs at reset values on the next cycle, no rsp_valid, no further strobes, cmd_ready=1 after release.
REQ-041 Run RD_LATENCY=3 with alternating write/read to addr 0..7 -> each rsp_data equals the prior write data, with strobes never overlapping.
